// File: rtl/tensor_core_pkg.sv
// Shared constants and tile typedefs for the tensor-core operand path.
package tensor_core_pkg;
  localparam int TILE_BEATS  = 12;
  localparam int ROWS        = 4;
  localparam int A_BASE      = 0;
  localparam int B_BASE      = 4;
  localparam int C_BASE      = 8;
  localparam int DEF_DWIDTH  = 16;
  localparam int DEF_AWIDTH  = 91;

  typedef logic [0:ROWS-1][0:ROWS-1][DEF_DWIDTH-1:0] ab_tile_t;
  typedef logic [0:ROWS-1][0:ROWS-1][DEF_AWIDTH-1:0] c_tile_t;
endpackage

// File: rtl/tensor_core_tile_bank.sv
// One staging bank: row writes steered by beat region, whole A/B/C matrices read out.
module tensor_core_tile_bank
  import tensor_core_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int AWIDTH = DEF_AWIDTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              we,
  input  logic [3:0]                        beat,
  input  logic [0:3][DWIDTH-1:0]            ab_row,
  input  logic [0:3][AWIDTH-1:0]            c_row,
  output logic [0:3][0:3][DWIDTH-1:0]       a,
  output logic [0:3][0:3][DWIDTH-1:0]       b,
  output logic [0:3][0:3][AWIDTH-1:0]       c
);
  logic [1:0] row;
  assign row = beat[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= '0;
      b <= '0;
      c <= '0;
    end else if (we) begin
      if (beat < 4'(B_BASE))      a[row] <= ab_row;
      else if (beat < 4'(C_BASE)) b[row] <= ab_row;
      else                        c[row] <= c_row;
    end
  end
endmodule

// File: rtl/tensor_core_tile_loader.sv
// Ping-pong tile assembler feeding tensor_core_gemm: fills one bank while the other is issued.
module tensor_core_tile_loader
  import tensor_core_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int AWIDTH = DEF_AWIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [0:3][DWIDTH-1:0]       s_ab,
  input  logic [0:3][AWIDTH-1:0]       s_c,
  input  logic                         s_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [0:3][0:3][DWIDTH-1:0]  A_out,
  output logic [0:3][0:3][DWIDTH-1:0]  B_out,
  output logic [0:3][0:3][AWIDTH-1:0]  C_out,
  output logic                         err_framing,
  output logic [15:0]                  tiles_issued
);
  logic [3:0] beat_cnt;
  logic       wp, rp;
  logic [1:0] occ;
  logic       acc, iss, last_beat, tile_done, abort;

  logic [1:0][0:3][0:3][DWIDTH-1:0] bank_a, bank_b;
  logic [1:0][0:3][0:3][AWIDTH-1:0] bank_c;

  // Handshake flags depend only on occ, so m_ready never reaches s_ready.
  assign s_ready   = (occ != 2'd2);
  assign m_valid   = (occ != 2'd0);
  assign acc       = s_valid & s_ready;
  assign iss       = m_valid & m_ready;
  assign last_beat = (beat_cnt == 4'(TILE_BEATS - 1));
  assign tile_done = acc & last_beat;
  assign abort     = acc & s_last & ~last_beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt     <= '0;
      wp           <= 1'b0;
      rp           <= 1'b0;
      occ          <= '0;
      tiles_issued <= '0;
      err_framing  <= 1'b0;
    end else begin
      err_framing <= abort | (tile_done & ~s_last);
      if (tile_done | abort) beat_cnt <= '0;
      else if (acc)          beat_cnt <= beat_cnt + 4'd1;
      if (tile_done) wp <= ~wp;
      if (iss) begin
        rp           <= ~rp;
        tiles_issued <= tiles_issued + 16'd1;
      end
      case ({tile_done, iss})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: ;
      endcase
    end
  end

  // Only bank wp is written; while it is full s_ready is low, so the presented bank is untouched.
  for (genvar i = 0; i < 2; i++) begin : g_bank
    tensor_core_tile_bank #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_bank (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (acc && (wp == 1'(i))),
      .beat   (beat_cnt),
      .ab_row (s_ab),
      .c_row  (s_c),
      .a      (bank_a[i]),
      .b      (bank_b[i]),
      .c      (bank_c[i])
    );
  end

  assign A_out = bank_a[rp];
  assign B_out = bank_b[rp];
  assign C_out = bank_c[rp];
endmodule

// File: tb/tb_tensor_core_tile_loader.sv
// Randomized bench for tensor_core_tile_loader against a tile-queue reference model.
module tb_tensor_core_tile_loader;
  localparam int DW = 16;
  localparam int AW = 91;

  typedef struct packed {
    logic [0:3][0:3][DW-1:0] a;
    logic [0:3][0:3][DW-1:0] b;
    logic [0:3][0:3][AW-1:0] c;
  } tile_t;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     s_valid = 1'b0;
  logic                     s_ready;
  logic [0:3][DW-1:0]       s_ab = '0;
  logic [0:3][AW-1:0]       s_c = '0;
  logic                     s_last = 1'b0;
  logic                     m_valid;
  logic                     m_ready = 1'b0;
  logic [0:3][0:3][DW-1:0]  A_out, B_out;
  logic [0:3][0:3][AW-1:0]  C_out;
  logic                     err_framing;
  logic [15:0]              tiles_issued;

  tensor_core_tile_loader #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_ab(s_ab),
    .s_c(s_c), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .A_out(A_out), .B_out(B_out), .C_out(C_out), .err_framing(err_framing),
    .tiles_issued(tiles_issued)
  );

  always #5 clk = ~clk;

  // Reference model: completed tiles waiting for issue, plus the tile being received.
  tile_t       exp_q[$];
  tile_t       got_q[$], want_q[$];
  tile_t       cur;
  int          beat_no = 0;
  logic        exp_err = 1'b0;
  logic [15:0] exp_issued = '0;
  int          mr_mode = 0;  // 0: m_ready low, 1: high, 2: random
  logic        last_acc = 1'b0;
  int          hs_bad = 0, err_bad = 0, err_seen = 0;
  int          errors = 0, checks = 0;

  function automatic tile_t rand_tile();
    tile_t t;
    logic [95:0] w;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) begin
        t.a[r][k] = 16'($urandom);
        t.b[r][k] = 16'($urandom);
        w = {$urandom, $urandom, $urandom};
        t.c[r][k] = w[AW-1:0];
      end
    return t;
  endfunction

  function automatic logic [0:3][AW-1:0] rand_crow();
    logic [0:3][AW-1:0] v;
    logic [95:0] w;
    for (int k = 0; k < 4; k++) begin
      w = {$urandom, $urandom, $urandom};
      v[k] = w[AW-1:0];
    end
    return v;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    got_q.delete();
    want_q.delete();
    beat_no    = 0;
    exp_err    = 1'b0;
    exp_issued = '0;
  endfunction

  // One clock: samples DUT at mid-cycle, captures issued tiles, advances the model.
  task automatic tick();
    logic  acc, iss;
    tile_t g;
    if (mr_mode == 2) m_ready = 1'($urandom_range(0, 1));
    else              m_ready = (mr_mode == 1);
    #1;
    if (s_ready !== (exp_q.size() != 2) || m_valid !== (exp_q.size() != 0)) hs_bad++;
    if (err_framing !== exp_err) err_bad++;
    if (err_framing === 1'b1) err_seen++;
    acc = s_valid && (exp_q.size() != 2);
    iss = m_ready && (exp_q.size() != 0);
    if (iss) begin
      g.a = A_out; g.b = B_out; g.c = C_out;
      got_q.push_back(g);
      want_q.push_back(exp_q[0]);
    end
    @(posedge clk);
    exp_err = 1'b0;
    if (iss) begin
      void'(exp_q.pop_front());
      exp_issued++;
    end
    if (acc) begin
      if (beat_no < 4)      cur.a[beat_no]     = s_ab;
      else if (beat_no < 8) cur.b[beat_no - 4] = s_ab;
      else                  cur.c[beat_no - 8] = s_c;
      if (beat_no == 11) begin
        exp_q.push_back(cur);
        exp_err = !s_last;
        beat_no = 0;
      end else if (s_last) begin
        exp_err = 1'b1;
        beat_no = 0;
      end else beat_no++;
    end
    last_acc = acc;
    @(negedge clk);
  endtask

  // Sends beats first..last of tile t; s_last is raised on beat slast_pos (-1: never).
  task automatic send_tile(input tile_t t, input int first, input int last,
                           input int slast_pos, input int gap_max);
    int waited;
    for (int k = first; k <= last; k++) begin
      s_valid = 1'b0;
      repeat ($urandom_range(0, gap_max)) tick();
      s_valid = 1'b1;
      s_ab    = (k < 4) ? t.a[k] : (k < 8) ? t.b[k-4] : {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      s_c     = (k >= 8) ? t.c[k-8] : rand_crow();
      s_last  = (k == slast_pos);
      waited  = 0;
      do begin
        tick();
        waited++;
      end while (!last_acc && waited < 200);
      checks++;
      if (!last_acc) begin
        errors++;
        $display("FAIL beat_timeout: beat %0d not accepted after %0d cycles, required acceptance", k, waited);
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    mr_mode = 1;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d tiles still pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready: got %b want 1", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    checks++; if (err_framing !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err_framing); end
    checks++; if (tiles_issued !== 16'd0) begin errors++; $display("FAIL rst_issued: got %0d want 0", tiles_issued); end
    checks++; if (A_out !== '0 || B_out !== '0) begin errors++; $display("FAIL rst_ab: got %h %h want 0", A_out, B_out); end
    rst_n = 1'b1;
    model_reset();
    repeat (2) tick();
  endtask

  task automatic test_single_tile();
    tile_t t, g, w;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) begin
        t.a[r][k] = 16'h3C00;
        t.b[r][k] = (r == k) ? 16'h3C00 : 16'h0000;
        t.c[r][k] = '0;
      end
    mr_mode = 0;
    send_tile(t, 0, 11, 11, 0);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_latency: m_valid got %b want 1", m_valid); end
    drain();
    checks++; if (tiles_issued !== 16'd1) begin errors++; $display("FAIL single_issued: got %0d want 1", tiles_issued); end
    while (got_q.size() != 0) begin
      g = got_q.pop_front(); w = want_q.pop_front();
      checks++; if (g.a !== w.a) begin errors++; $display("FAIL single_A: got %h want %h", g.a, w.a); end
      checks++; if (g.b !== w.b) begin errors++; $display("FAIL single_B: got %h want %h", g.b, w.b); end
      for (int r = 0; r < 4; r++) begin
        checks++; if (g.c[r] !== w.c[r]) begin errors++; $display("FAIL single_C%0d: got %h want %h", r, g.c[r], w.c[r]); end
      end
    end
  endtask

  task automatic test_back_pressure();
    tile_t t1, t2, t3, g, w;
    logic [15:0] start = tiles_issued;
    int stalls = 0;
    t1 = rand_tile(); t2 = rand_tile(); t3 = rand_tile();
    mr_mode = 0;
    send_tile(t1, 0, 11, 11, 0);
    send_tile(t2, 0, 11, 11, 0);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_drop: got %b want 0", s_ready); end
    s_valid = 1'b1; s_ab = t3.a[0]; s_c = rand_crow();
    repeat (4) begin
      tick();
      if (last_acc) stalls++;
    end
    checks++; if (stalls != 0 || s_ready !== 1'b0) begin errors++; $display("FAIL bp_stall: accepted %0d ready %b want 0 0", stalls, s_ready); end
    mr_mode = 1;
    send_tile(t3, 0, 11, 11, 0);
    drain();
    checks++; if (tiles_issued !== 16'(start + 16'd3)) begin errors++; $display("FAIL bp_issued: got %0d want %0d", tiles_issued, start + 16'd3); end
    checks++; if (want_q.size() != 3 || want_q[0] !== t1 || want_q[1] !== t2 || want_q[2] !== t3) begin errors++; $display("FAIL bp_order: issued %0d tiles, required t1,t2,t3", want_q.size()); end
    while (got_q.size() != 0) begin
      g = got_q.pop_front(); w = want_q.pop_front();
      checks++; if (g.a !== w.a) begin errors++; $display("FAIL bp_A: got %h want %h", g.a, w.a); end
      checks++; if (g.b !== w.b) begin errors++; $display("FAIL bp_B: got %h want %h", g.b, w.b); end
      for (int r = 0; r < 4; r++) begin
        checks++; if (g.c[r] !== w.c[r]) begin errors++; $display("FAIL bp_C%0d: got %h want %h", r, g.c[r], w.c[r]); end
      end
    end
  endtask

  task automatic test_simultaneous();
    tile_t t1, t2, g, w;
    t1 = rand_tile(); t2 = rand_tile();
    mr_mode = 0;
    send_tile(t1, 0, 11, 11, 0);
    send_tile(t2, 0, 10, 11, 0);
    mr_mode = 1;
    send_tile(t2, 11, 11, 11, 0);
    checks++; if (m_valid !== 1'b1 || s_ready !== 1'b1) begin errors++; $display("FAIL simul_occ: valid %b ready %b want 1 1", m_valid, s_ready); end
    checks++; if (A_out !== t2.a) begin errors++; $display("FAIL simul_present: got %h want %h", A_out, t2.a); end
    drain();
    while (got_q.size() != 0) begin
      g = got_q.pop_front(); w = want_q.pop_front();
      checks++; if (g.a !== w.a || g.b !== w.b) begin errors++; $display("FAIL simul_AB: got %h want %h", g.a, w.a); end
      for (int r = 0; r < 4; r++) begin
        checks++; if (g.c[r] !== w.c[r]) begin errors++; $display("FAIL simul_C%0d: got %h want %h", r, g.c[r], w.c[r]); end
      end
    end
  endtask

  task automatic test_framing();
    tile_t ta, tb_, tm, g, w;
    logic [15:0] start = tiles_issued;
    int e0 = err_seen;
    ta = rand_tile(); tb_ = rand_tile(); tm = rand_tile();
    mr_mode = 1;
    send_tile(ta, 0, 5, 5, 0);
    send_tile(tb_, 0, 11, 11, 0);
    drain();
    checks++; if (err_seen - e0 != 1) begin errors++; $display("FAIL early_last_pulse: got %0d pulses want 1", err_seen - e0); end
    checks++; if (tiles_issued !== 16'(start + 16'd1)) begin errors++; $display("FAIL early_last_issued: got %0d want %0d", tiles_issued, start + 16'd1); end
    e0 = err_seen;
    send_tile(tm, 0, 11, -1, 0);
    drain();
    checks++; if (err_seen - e0 != 1) begin errors++; $display("FAIL missing_last_pulse: got %0d pulses want 1", err_seen - e0); end
    checks++; if (tiles_issued !== 16'(start + 16'd2)) begin errors++; $display("FAIL missing_last_issued: got %0d want %0d", tiles_issued, start + 16'd2); end
    while (got_q.size() != 0) begin
      g = got_q.pop_front(); w = want_q.pop_front();
      checks++; if (g.a !== w.a || g.b !== w.b) begin errors++; $display("FAIL framing_AB: got %h want %h", g.a, w.a); end
      for (int r = 0; r < 4; r++) begin
        checks++; if (g.c[r] !== w.c[r]) begin errors++; $display("FAIL framing_C%0d: got %h want %h", r, g.c[r], w.c[r]); end
      end
    end
  endtask

  task automatic test_random();
    tile_t g, w;
    for (int n = 0; n < 12; n++) begin
      int sel = $urandom_range(0, 9);
      mr_mode = 2;
      if (sel == 0) begin
        int p = $urandom_range(0, 10);
        send_tile(rand_tile(), 0, p, p, 2);
      end else if (sel == 1) send_tile(rand_tile(), 0, 11, -1, 2);
      else                   send_tile(rand_tile(), 0, 11, 11, 2);
    end
    drain();
    while (got_q.size() != 0) begin
      g = got_q.pop_front(); w = want_q.pop_front();
      checks++; if (g.a !== w.a || g.b !== w.b) begin errors++; $display("FAIL rand_AB: got %h want %h", g.a, w.a); end
      for (int r = 0; r < 4; r++) begin
        checks++; if (g.c[r] !== w.c[r]) begin errors++; $display("FAIL rand_C%0d: got %h want %h", r, g.c[r], w.c[r]); end
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    tile_t t1, t2, t3, g, w;
    t1 = rand_tile(); t2 = rand_tile(); t3 = rand_tile();
    mr_mode = 0;
    send_tile(t1, 0, 11, 11, 0);
    send_tile(t2, 0, 5, -1, 0);
    s_valid = 1'b1; s_ab = t2.b[2]; s_c = rand_crow();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin errors++; $display("FAIL rstmid_hs: valid %b ready %b want 0 1", m_valid, s_ready); end
    checks++; if (tiles_issued !== 16'd0) begin errors++; $display("FAIL rstmid_issued: got %0d want 0", tiles_issued); end
    checks++; if (A_out !== '0 || B_out !== '0) begin errors++; $display("FAIL rstmid_ab: got %h %h want 0", A_out, B_out); end
    checks++; if (C_out !== '0) begin errors++; $display("FAIL rstmid_c: got %h want 0", C_out); end
    model_reset();
    @(negedge clk);
    s_valid = 1'b0;
    rst_n = 1'b1;
    mr_mode = 1;
    repeat (3) tick();
    send_tile(t3, 0, 11, 11, 0);
    drain();
    checks++; if (tiles_issued !== 16'd1) begin errors++; $display("FAIL rstmid_after: got %0d want 1", tiles_issued); end
    while (got_q.size() != 0) begin
      g = got_q.pop_front(); w = want_q.pop_front();
      checks++; if (g.a !== t3.a || g.b !== w.b) begin errors++; $display("FAIL rstmid_AB: got %h want %h", g.a, t3.a); end
      for (int r = 0; r < 4; r++) begin
        checks++; if (g.c[r] !== w.c[r]) begin errors++; $display("FAIL rstmid_C%0d: got %h want %h", r, g.c[r], w.c[r]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_back_pressure();
    test_simultaneous();
    test_framing();
    test_random();
    checks++; if (hs_bad != 0) begin errors++; $display("FAIL handshake_flags: %0d bad cycles, required 0", hs_bad); end
    checks++; if (err_bad != 0) begin errors++; $display("FAIL err_timing: %0d bad cycles, required 0", err_bad); end
    test_reset_mid_fill();
    checks++; if (hs_bad != 0 || err_bad != 0) begin errors++; $display("FAIL post_reset_flags: hs %0d err %0d, required 0 0", hs_bad, err_bad); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
